// File: rtl/rsp_order_mux_pkg.sv
// Shared types and helpers for the response-ordering mux and the outstanding-ID tracker.
package rsp_order_mux_pkg;

    localparam int unsigned SID_W       = 8;
    localparam logic [SID_W-1:0] SID_EMPTY = 8'h00;
    localparam int unsigned TABLE_DEPTH = 4;
    localparam int unsigned NUM_PORTS   = 3;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned CNT_W       = 9;
    localparam int unsigned RESP_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Non-data sideband of one R beat.
    typedef struct packed {
        logic [SID_W-1:0]  id;
        logic [RESP_W-1:0] resp;
        logic              last;
    } rsp_meta_t;

    // Lowest-index requester wins.
    function automatic logic [SEL_W-1:0] priority_sel(input logic [NUM_PORTS-1:0] req);
        logic [SEL_W-1:0] sel;
        logic             found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && !found) begin
                sel   = SEL_W'(i);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rsp_order_mux_if.sv
// One AXI-style R channel (id, data, resp, last, valid/ready).
interface rsp_order_mux_if #(parameter int unsigned DW = 32);
    import rsp_order_mux_pkg::*;

    logic [SID_W-1:0]  rid;
    logic [DW-1:0]     rdata;
    logic [RESP_W-1:0] rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (output rid, rdata, rresp, rlast, rvalid, input  rready);
    modport slave  (input  rid, rdata, rresp, rlast, rvalid, output rready);
endinterface

// File: rtl/rsp_order_mux_out_reg.sv
// Single-entry valid/ready output register for the merged R channel.
module rsp_out_reg
    import rsp_order_mux_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_load,
    input  rsp_meta_t     i_meta,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output rsp_meta_t     o_meta,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    rsp_meta_t     r_meta;
    logic [DW-1:0] r_data;

    // Load wins over drain so load+drain in one cycle keeps the slot full.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_meta  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_meta  <= i_meta;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_meta  = r_meta;
    assign o_data  = r_data;

endmodule

// File: rtl/rsp_order_mux.sv
// Merges three slave R channels onto one master R channel in outstanding-ID table order.
module rsp_order_mux
    import rsp_order_mux_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [SID_W*TABLE_DEPTH-1:0] sid_table,
    rsp_order_mux_if.slave               s0,
    rsp_order_mux_if.slave               s1,
    rsp_order_mux_if.slave               s2,
    rsp_order_mux_if.master              m,
    output logic                         last_0,
    output logic                         last_1,
    output logic                         last_2,
    output logic [SID_W-1:0]             sid_0,
    output logic [SID_W-1:0]             sid_1,
    output logic [SID_W-1:0]             sid_2,
    output logic                         sid_0_vld,
    output logic                         sid_1_vld,
    output logic                         sid_2_vld,
    input  logic                         sid_0_clr_rdy,
    input  logic                         sid_1_clr_rdy,
    input  logic                         sid_2_clr_rdy,
    output logic                         err_overrun
);

    state_e                r_state, w_state_nxt;
    logic [SEL_W-1:0]      r_sel, w_sel_nxt;
    logic [SID_W-1:0]      r_lock_id, w_lock_id_nxt;
    logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
    logic                  r_err_overrun, w_err_nxt;

    logic [SID_W-1:0]      w_head;
    logic                  w_unused_tbl;
    logic [NUM_PORTS-1:0]  w_match;
    logic [NUM_PORTS-1:0]  w_rready;
    logic [NUM_PORTS-1:0]  w_clr_vld;
    logic [DW-1:0]         w_sel_data;
    logic [RESP_W-1:0]     w_sel_resp;
    logic                  w_sel_last;
    logic                  w_sel_valid;
    logic                  w_sel_clr_rdy;
    logic                  w_slot_free;
    logic                  w_load;
    rsp_meta_t             w_load_meta;
    logic                  w_out_valid;
    rsp_meta_t             w_out_meta;
    logic [DW-1:0]         w_out_data;

    assign w_head       = sid_table[SID_W-1:0];
    assign w_unused_tbl = ^sid_table[SID_W*TABLE_DEPTH-1:SID_W];

    assign w_match[0] = s0.rvalid && (s0.rid == w_head) && (w_head != SID_EMPTY);
    assign w_match[1] = s1.rvalid && (s1.rid == w_head) && (w_head != SID_EMPTY);
    assign w_match[2] = s2.rvalid && (s2.rid == w_head) && (w_head != SID_EMPTY);

    assign w_slot_free = !w_out_valid || m.rready;

    // Route the locked port's beat and clear-ready.
    always_comb begin
        w_sel_data    = s0.rdata;
        w_sel_resp    = s0.rresp;
        w_sel_last    = s0.rlast;
        w_sel_valid   = s0.rvalid;
        w_sel_clr_rdy = sid_0_clr_rdy;
        case (r_sel)
            2'd1: begin
                w_sel_data    = s1.rdata;
                w_sel_resp    = s1.rresp;
                w_sel_last    = s1.rlast;
                w_sel_valid   = s1.rvalid;
                w_sel_clr_rdy = sid_1_clr_rdy;
            end
            2'd2: begin
                w_sel_data    = s2.rdata;
                w_sel_resp    = s2.rresp;
                w_sel_last    = s2.rlast;
                w_sel_valid   = s2.rvalid;
                w_sel_clr_rdy = sid_2_clr_rdy;
            end
            default: ;
        endcase
    end

    // FSM state and burst bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_lock_id     <= '0;
            r_beat_cnt    <= '0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_lock_id     <= w_lock_id_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_err_overrun <= w_err_nxt;
        end
    end

    // Next-state, per-port ready and clear-request decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_lock_id_nxt  = r_lock_id;
        w_beat_cnt_nxt = r_beat_cnt;
        w_err_nxt      = r_err_overrun;
        w_rready       = '0;
        w_clr_vld      = '0;
        w_load         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_match) begin
                    w_sel_nxt      = priority_sel(w_match);
                    w_lock_id_nxt  = w_head;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = ST_BURST;
                end
            end
            ST_BURST: begin
                for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                    w_rready[k] = (r_sel == SEL_W'(k)) && w_slot_free;
                end
                w_load = w_sel_valid && w_slot_free;
                if (w_load) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    if (w_sel_last) begin
                        w_state_nxt = ST_CLEAR;
                    end else if (r_beat_cnt + CNT_W'(1) == CNT_W'(MAX_BEATS)) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                    w_clr_vld[k] = (r_sel == SEL_W'(k));
                end
                if (w_sel_clr_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_load_meta = '{id: r_lock_id, resp: w_sel_resp, last: w_sel_last};

    rsp_out_reg #(.DW(DW)) u_out_reg (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_load),
        .i_meta  (w_load_meta),
        .i_data  (w_sel_data),
        .i_ready (m.rready),
        .o_valid (w_out_valid),
        .o_meta  (w_out_meta),
        .o_data  (w_out_data)
    );

    assign m.rvalid = w_out_valid;
    assign m.rid    = w_out_meta.id;
    assign m.rresp  = w_out_meta.resp;
    assign m.rlast  = w_out_meta.last;
    assign m.rdata  = w_out_data;

    assign s0.rready = w_rready[0];
    assign s1.rready = w_rready[1];
    assign s2.rready = w_rready[2];

    assign sid_0_vld = w_clr_vld[0];
    assign sid_1_vld = w_clr_vld[1];
    assign sid_2_vld = w_clr_vld[2];
    assign last_0    = w_clr_vld[0];
    assign last_1    = w_clr_vld[1];
    assign last_2    = w_clr_vld[2];
    assign sid_0     = w_clr_vld[0] ? r_lock_id : '0;
    assign sid_1     = w_clr_vld[1] ? r_lock_id : '0;
    assign sid_2     = w_clr_vld[2] ? r_lock_id : '0;

    assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_rsp_order_mux.sv
// Directed bench for rsp_order_mux: ordering, tie-break, backpressure, overrun, reset.
module tb_rsp_order_mux;

    logic        clk;
    logic        rstn;
    logic [31:0] sid_table;
    logic [2:0]  clr_rdy;
    logic        last_0, last_1, last_2;
    logic [7:0]  sid_0, sid_1, sid_2;
    logic        sid_0_vld, sid_1_vld, sid_2_vld;
    logic        err_overrun;

    rsp_order_mux_if #(.DW(32)) s0_if ();
    rsp_order_mux_if #(.DW(32)) s1_if ();
    rsp_order_mux_if #(.DW(32)) s2_if ();
    rsp_order_mux_if #(.DW(32)) m_if ();

    rsp_order_mux #(.DW(32), .MAX_BEATS(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .sid_table     (sid_table),
        .s0            (s0_if),
        .s1            (s1_if),
        .s2            (s2_if),
        .m             (m_if),
        .last_0        (last_0),
        .last_1        (last_1),
        .last_2        (last_2),
        .sid_0         (sid_0),
        .sid_1         (sid_1),
        .sid_2         (sid_2),
        .sid_0_vld     (sid_0_vld),
        .sid_1_vld     (sid_1_vld),
        .sid_2_vld     (sid_2_vld),
        .sid_0_clr_rdy (clr_rdy[0]),
        .sid_1_clr_rdy (clr_rdy[1]),
        .sid_2_clr_rdy (clr_rdy[2]),
        .err_overrun   (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [42:0] q_beats[$];
    int          rr_cnt[3];
    int          n_viol  = 0;
    int          clr_cnt = 0;
    logic [7:0]  clr_id  = 8'h00;
    bit          clr_pend  = 1'b0;
    bit          toggle_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [42:0] exp_beat(input logic l, input logic [1:0] r,
                                             input logic [7:0] id, input logic [31:0] d);
        return {l, r, id, d};
    endfunction

    task automatic drive(input int port, input logic v, input logic [7:0] id,
                         input logic [31:0] d, input logic [1:0] r, input logic l);
        case (port)
            0: begin s0_if.rvalid = v; s0_if.rid = id; s0_if.rdata = d; s0_if.rresp = r; s0_if.rlast = l; end
            1: begin s1_if.rvalid = v; s1_if.rid = id; s1_if.rdata = d; s1_if.rresp = r; s1_if.rlast = l; end
            default: begin s2_if.rvalid = v; s2_if.rid = id; s2_if.rdata = d; s2_if.rresp = r; s2_if.rlast = l; end
        endcase
    endtask

    function automatic logic port_rready(input int port);
        case (port)
            0:       return s0_if.rready;
            1:       return s1_if.rready;
            default: return s2_if.rready;
        endcase
    endfunction

    // Source model: presents n beats, returns how many were accepted before a stall timeout.
    task automatic send(input int port, input logic [7:0] id, input int n, input logic [31:0] base,
                        input bit with_last, output int acc);
        int budget;
        acc = 0;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            drive(port, 1'b1, id, base + 32'(b), 2'(b), with_last && (b == n - 1));
            budget = 0;
            #3;
            while (!port_rready(port) && budget < 40) begin
                @(negedge clk);
                #3;
                budget++;
            end
            if (!port_rready(port)) break;
            acc++;
        end
        @(negedge clk);
        drive(port, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    endtask

    // Tracker model and channel monitor, sampled just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (clr_pend) begin
                sid_table = {8'h00, sid_table[31:8]};
                clr_pend  = 1'b0;
            end
            if (toggle_en) m_if.rready = ~m_if.rready;
            #3;
            if (rstn) begin
                if (m_if.rvalid && m_if.rready)
                    q_beats.push_back({m_if.rlast, m_if.rresp, m_if.rid, m_if.rdata});
                if (s0_if.rready) rr_cnt[0]++;
                if (s1_if.rready) rr_cnt[1]++;
                if (s2_if.rready) rr_cnt[2]++;
                if ((s0_if.rready || s1_if.rready || s2_if.rready) && m_if.rvalid && !m_if.rready)
                    n_viol++;
                if (sid_0_vld && clr_rdy[0]) begin clr_pend = 1'b1; clr_id = sid_0; clr_cnt++; end
                if (sid_1_vld && clr_rdy[1]) begin clr_pend = 1'b1; clr_id = sid_1; clr_cnt++; end
                if (sid_2_vld && clr_rdy[2]) begin clr_pend = 1'b1; clr_id = sid_2; clr_cnt++; end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int acc0, acc1, acc2, wait_cyc, clr_before;
        logic [42:0] exp_q[$];

        rstn = 1'b0;
        sid_table = 32'h0;
        clr_rdy = 3'b000;
        m_if.rready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            drive(p, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
            rr_cnt[p] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        #4;
        chk("rst_m_rvalid", 64'(m_if.rvalid), 64'd0);
        chk("rst_m_rdata",  64'(m_if.rdata), 64'd0);
        chk("rst_m_rid",    64'(m_if.rid), 64'd0);
        chk("rst_rready",   64'({s2_if.rready, s1_if.rready, s0_if.rready}), 64'd0);
        chk("rst_clr_vld",  64'({sid_2_vld, sid_1_vld, sid_0_vld}), 64'd0);
        chk("rst_err",      64'(err_overrun), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Empty table: a response carrying ID 0 must never be accepted
        drive(0, 1'b1, 8'h00, 32'hDEAD, 2'b00, 1'b1);
        repeat (4) @(negedge clk);
        drive(0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
        #4;
        chk("empty_rready0", 64'(rr_cnt[0]), 64'd0);
        chk("empty_no_beat", 64'(q_beats.size()), 64'd0);

        // Single burst from port 1, clear held off by the tracker
        sid_table = 32'h0000_0005;
        send(1, 8'h05, 4, 32'h100, 1'b1, acc1);
        chk("t1_acc", 64'(acc1), 64'd4);
        repeat (2) @(negedge clk);
        #4;
        chk("t1_nbeats", 64'(q_beats.size()), 64'd4);
        for (int b = 0; b < 4; b++)
            chk($sformatf("t1_beat%0d", b), 64'(q_beats[b]),
                64'(exp_beat(b == 3, 2'(b), 8'h05, 32'h100 + 32'(b))));
        chk("t1_rr0_idle",  64'(rr_cnt[0]), 64'd0);
        chk("t1_rr2_idle",  64'(rr_cnt[2]), 64'd0);
        chk("t1_sid1_vld",  64'(sid_1_vld), 64'd1);
        chk("t1_last1",     64'(last_1), 64'd1);
        chk("t1_sid1",      64'(sid_1), 64'h05);
        chk("t1_other_vld", 64'({sid_2_vld, sid_0_vld}), 64'd0);
        chk("t1_m_drained", 64'(m_if.rvalid), 64'd0);
        chk("t1_no_err",    64'(err_overrun), 64'd0);
        @(negedge clk);
        clr_rdy = 3'b111;
        repeat (2) @(negedge clk);
        #4;
        chk("t1_clr_done",  64'(sid_1_vld), 64'd0);
        chk("t1_clr_id",    64'(clr_id), 64'h05);
        chk("t1_table",     64'(sid_table), 64'd0);

        // Ordering: head 03 (port 2) goes before 07 (port 0)
        q_beats.delete();
        sid_table = 32'h0000_0703;
        fork
            send(0, 8'h07, 2, 32'h700, 1'b1, acc0);
            send(2, 8'h03, 3, 32'h300, 1'b1, acc2);
        join
        repeat (4) @(negedge clk);
        #4;
        chk("t2_acc0", 64'(acc0), 64'd2);
        chk("t2_acc2", 64'(acc2), 64'd3);
        chk("t2_nbeats", 64'(q_beats.size()), 64'd5);
        exp_q.delete();
        for (int b = 0; b < 3; b++) exp_q.push_back(exp_beat(b == 2, 2'(b), 8'h03, 32'h300 + 32'(b)));
        for (int b = 0; b < 2; b++) exp_q.push_back(exp_beat(b == 1, 2'(b), 8'h07, 32'h700 + 32'(b)));
        for (int i = 0; i < 5; i++)
            chk($sformatf("t2_beat%0d", i), 64'(q_beats[i]), 64'(exp_q[i]));
        chk("t2_table", 64'(sid_table), 64'd0);

        // Backpressure: master ready alternates every cycle
        q_beats.delete();
        n_viol = 0;
        sid_table = 32'h0000_000A;
        #4;
        toggle_en = 1'b1;
        send(1, 8'h0A, 4, 32'hA00, 1'b1, acc1);
        repeat (4) @(negedge clk);
        #1;
        toggle_en = 1'b0;
        m_if.rready = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        chk("t3_acc", 64'(acc1), 64'd4);
        chk("t3_nbeats", 64'(q_beats.size()), 64'd4);
        for (int b = 0; b < 4; b++)
            chk($sformatf("t3_beat%0d", b), 64'(q_beats[b]),
                64'(exp_beat(b == 3, 2'(b), 8'h0A, 32'hA00 + 32'(b))));
        chk("t3_no_accept_when_full", 64'(n_viol), 64'd0);

        // Tie: ports 0 and 2 both carry head ID 9; port 0 first
        q_beats.delete();
        sid_table = 32'h0000_0909;
        fork
            send(0, 8'h09, 2, 32'h900, 1'b1, acc0);
            send(2, 8'h09, 2, 32'h920, 1'b1, acc2);
        join
        repeat (4) @(negedge clk);
        #4;
        chk("t4_nbeats", 64'(q_beats.size()), 64'd4);
        chk("t4_beat0", 64'(q_beats[0]), 64'(exp_beat(1'b0, 2'd0, 8'h09, 32'h900)));
        chk("t4_beat1", 64'(q_beats[1]), 64'(exp_beat(1'b1, 2'd1, 8'h09, 32'h901)));
        chk("t4_beat2", 64'(q_beats[2]), 64'(exp_beat(1'b0, 2'd0, 8'h09, 32'h920)));
        chk("t4_beat3", 64'(q_beats[3]), 64'(exp_beat(1'b1, 2'd1, 8'h09, 32'h921)));

        // Overrun: 6 beats without rlast, only MAX_BEATS=4 forwarded
        q_beats.delete();
        clr_before = clr_cnt;
        sid_table = 32'h0000_0011;
        send(0, 8'h11, 6, 32'hB00, 1'b0, acc0);
        #4;
        chk("t5_acc", 64'(acc0), 64'd4);
        chk("t5_err", 64'(err_overrun), 64'd1);
        chk("t5_nbeats", 64'(q_beats.size()), 64'd4);
        chk("t5_beat3", 64'(q_beats[3]), 64'(exp_beat(1'b0, 2'd3, 8'h11, 32'hB03)));
        chk("t5_clr_cnt", 64'(clr_cnt - clr_before), 64'd1);
        chk("t5_clr_id", 64'(clr_id), 64'h11);
        repeat (3) @(negedge clk);
        #4;
        chk("t5_err_sticky", 64'(err_overrun), 64'd1);

        // Reset during the second beat
        q_beats.delete();
        @(negedge clk);
        sid_table = 32'h0000_0033;
        drive(1, 1'b1, 8'h33, 32'h3300, 2'b00, 1'b0);
        wait_cyc = 0;
        while (q_beats.size() < 1 && wait_cyc < 20) begin
            @(negedge clk);
            #4;
            wait_cyc++;
        end
        chk("t6_first_beat", 64'(q_beats.size()), 64'd1);
        @(negedge clk);
        drive(1, 1'b1, 8'h33, 32'h3301, 2'b01, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        sid_table = 32'h0;
        drive(1, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
        #4;
        chk("t6_m_rvalid", 64'(m_if.rvalid), 64'd0);
        chk("t6_m_rdata",  64'(m_if.rdata), 64'd0);
        chk("t6_m_rid",    64'(m_if.rid), 64'd0);
        chk("t6_m_rresp",  64'({m_if.rlast, m_if.rresp}), 64'd0);
        chk("t6_rready",   64'({s2_if.rready, s1_if.rready, s0_if.rready}), 64'd0);
        chk("t6_clr_vld",  64'({sid_2_vld, sid_1_vld, sid_0_vld}), 64'd0);
        chk("t6_err",      64'(err_overrun), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rsp_order_mux.md
# rsp_order_mux

Response-return side of the outstanding-ID tracker: merges the read-response channels of three slave ports onto one master R channel, strictly in the order held in the outstanding-ID table. Only a burst whose ID equals the oldest outstanding entry (table head) is forwarded. On its last beat the block issues the per-port clear handshake that retires that entry from the table. Sits between the slave-port R channels and the master R channel, alongside the ID tracker.

## Interface

Parameters:
- DW, 32, R data width
- MAX_BEATS, 256, max beats per burst before overrun is flagged

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- sid_table  in  32  outstanding-ID table; entry i = bits [8i+7:8i]; entry 0 is the head (oldest); value 8'h00 means empty
- sK_rid  in  8  port K response ID (K = 0,1,2)
- sK_rdata  in  DW  port K data
- sK_rresp  in  2  port K response code
- sK_rlast  in  1  port K last beat
- sK_rvalid  in  1  port K beat valid
- sK_rready  out  1  port K beat accept
- m_rid  out  8  merged response ID
- m_rdata  out  DW  merged data
- m_rresp  out  2  merged response code
- m_rlast  out  1  merged last beat
- m_rvalid  out  1  merged valid
- m_rready  in  1  master accept
- last_K  out  1  clear request, last-beat qualifier, port K
- sid_K  out  8  ID to retire, port K
- sid_K_vld  out  1  clear request valid, port K
- sid_K_clr_rdy  in  1  tracker accepts clear, port K
- err_overrun  out  1  sticky: burst exceeded MAX_BEATS

## Operation

- FSM states: IDLE, BURST, CLEAR. Registered state: sel[1:0], lock_id[7:0], beat_cnt[8:0].
- IDLE:
  - If head != 0 and some port K has sK_rvalid && sK_rid == head: latch sel = lowest such K and lock_id = head; clear beat_cnt; go to BURST.
  - Otherwise stay in IDLE. Responses from non-head IDs are never accepted; they stall.
- BURST:
  - sK_rready = (K == sel) && (!m_rvalid || m_rready). All other ports get rready = 0.
  - An accepted beat loads the single output register: m_rid = lock_id; m_rdata, m_rresp, m_rlast come from the port. beat_cnt increments.
  - An accepted beat with rlast set moves to CLEAR.
  - If beat_cnt reaches MAX_BEATS without rlast: set err_overrun and go to CLEAR.
- CLEAR:
  - For port sel only, drive sid_K_vld = 1, last_K = 1, sid_K = lock_id. All other ports' clear outputs are 0.
  - Hold these until sid_K_clr_rdy = 1, then go to IDLE.
- Output register:
  - m_rvalid clears when m_rready is high and no new beat loads in the same cycle.
  - Load and drain in the same cycle sustain 1 beat/cycle.
  - The register drains independently of FSM state, including in CLEAR and IDLE.
- Head changes while in BURST or CLEAR are ignored; lock_id governs until return to IDLE.

## Timing

- Reset values: FSM = IDLE; all sK_rready = 0; m_rvalid = 0; m_rid, m_rdata, m_rresp, m_rlast = 0; all last_K, sid_K, sid_K_vld = 0; err_overrun = 0.
- Reset mid-burst drops any partial burst and the contents of the output register.
- Match in IDLE at cycle N → BURST at N+1. The first rready can assert at N+1.
- Beat accepted at cycle N → visible on m_r* at N+1.
- Back-to-back beats stream at 1/cycle while m_rready = 1.
- Last beat accepted at N → CLEAR at N+1, with the clear request visible at N+1.
- Clear accepted at cycle M → IDLE at M+1. The tracker updates at the edge ending M, so the updated head is seen in IDLE at M+1. Earliest next match: M+1.
- Minimum bubble between bursts: 2 cycles (CLEAR plus IDLE). Bubbles on the master side appear only when the output register empties.
- Simultaneous matching ports: lowest index wins. A head match from port 0 on the cycle the previous clear is accepted is not seen until M+1.
- Empty table (head = 0): block stays in IDLE; all rready = 0.

## Structure

- Shared package: SID_W = 8, SID_EMPTY = 8'h00, TABLE_DEPTH = 4, NUM_PORTS = 3, FSM state enum, and the priority_sel lowest-index-first function (shared with the tracker).
- One natural sub-module: rsp_out_reg. It is the single-entry valid/ready output register, carrying id, data, resp and last.

## Test plan

- Single burst:
  - Stimulus: head = 8'h05; port 1 sends 4 beats with rid 5.
  - Response: 4 beats on m_r* with m_rid = 5 and last on beat 4; last_1/sid_1 = 5/sid_1_vld asserted until clr_rdy; ports 0 and 2 have rready = 0 throughout.
- Ordering:
  - Stimulus: table = {00,00,07,03}; port 0 presents rid 7 first, port 2 presents rid 3.
  - Response: the ID-3 burst is forwarded first; the ID-7 burst starts only after the clear and the table shifts.
- Backpressure:
  - Stimulus: m_rready toggles 1010…
  - Response: no beat lost or duplicated; rready is low whenever the output register is full and m_rready is low.
- Tie:
  - Stimulus: head = 9; ports 0 and 2 both present rid 9.
  - Response: port 0 is granted; port 2 stalls until the next match.
- Overrun:
  - Stimulus: MAX_BEATS = 4; port 0 sends 6 beats with no rlast.
  - Response: after 4 beats err_overrun = 1 (sticky) and the block enters CLEAR.
- Reset mid-burst:
  - Stimulus: rstn low for 1 cycle during beat 2.
  - Response: next cycle all outputs are at reset values and the FSM is in IDLE.
